// File: rtl/ticket_booth_ctrl.sv
// Cinema ticket-vending controller: movie -> session -> seats -> payment -> change.
// Optional inactivity timeout is compiled in with the TICKET_TIMEOUT_EN macro.
module ticket_booth_ctrl #(
  parameter int N_MOVIES    = 2,
  parameter int N_SESSIONS  = 2,
  parameter int N_SEATS     = 18,
  parameter int PRICE       = 15,
  parameter int CREDIT_W    = 10,
  parameter int COIN0       = 5,
  parameter int COIN1       = 10,
  parameter int COIN2       = 20,
  parameter int COIN3       = 50,
  parameter int TIMEOUT_CYC = 50_000_000,
  localparam int MW    = (N_MOVIES > 1) ? $clog2(N_MOVIES) : 1,
  localparam int SW    = (N_SESSIONS > 1) ? $clog2(N_SESSIONS) : 1,
  localparam int N_ENT = N_MOVIES * N_SESSIONS,
  localparam int SELW  = (N_ENT > 1) ? $clog2(N_ENT) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          key_n,
  input  logic [N_SEATS-1:0]  sw,
  input  logic                cancel,
  output logic [2:0]          state,
  output logic [MW-1:0]       movie_idx,
  output logic [SW-1:0]       session_idx,
  output logic [N_SEATS-1:0]  seat_free,
  output logic [CREDIT_W-1:0] due,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] change,
  output logic                change_valid,
  output logic                err
);

  typedef enum logic [2:0] {
    S_MOVIE   = 3'd0,
    S_SESSION = 3'd1,
    S_SEATS   = 3'd2,
    S_PAY     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  function automatic logic [CREDIT_W-1:0] seat_price(input logic [N_SEATS-1:0] req);
    int cnt;
    cnt = 0;
    for (int i = 0; i < N_SEATS; i++) begin
      if (req[i]) cnt++;
    end
    return CREDIT_W'(cnt * PRICE);
  endfunction

  state_t              r_state, w_state_nx;
  logic [3:0]          r_key_s1, r_key_s2, r_key_d;
  logic [MW-1:0]       r_movie, w_movie_nx, w_movie_inc;
  logic [SW-1:0]       r_session, w_session_nx, w_session_inc;
  logic [CREDIT_W-1:0] r_due, w_due_nx, r_credit, w_credit_nx, r_change, w_change_nx;
  logic [CREDIT_W-1:0] w_credit_sat;
  logic [CREDIT_W:0]   w_coin, w_sum;
  logic                r_cv, w_cv_nx, r_err, w_err_nx, w_commit;
  logic [N_SEATS-1:0]  r_req, w_req_nx, w_occ_cur;
  logic [N_SEATS-1:0]  r_occ [N_ENT];
  logic [SELW-1:0]     w_sel;
  logic [3:0]          w_fall, w_key;
  logic                w_timeout, w_abort;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_s1 <= 4'hF;
      r_key_s2 <= 4'hF;
      r_key_d  <= 4'hF;
    end else begin
      r_key_s1 <= key_n;
      r_key_s2 <= r_key_s1;
      r_key_d  <= r_key_s2;
    end
  end

  // Keep only the lowest-index press when several land in one cycle.
  assign w_fall = r_key_d & ~r_key_s2;
  assign w_key  = w_fall & (~w_fall + 4'd1);

  assign w_sel     = SELW'(int'(r_movie) * N_SESSIONS + int'(r_session));
  assign w_occ_cur = r_occ[w_sel];

  assign w_movie_inc   = (r_movie == MW'(N_MOVIES - 1)) ? '0 : r_movie + MW'(1);
  assign w_session_inc = (r_session == SW'(N_SESSIONS - 1)) ? '0 : r_session + SW'(1);

  assign w_coin = w_key[0] ? (CREDIT_W+1)'(COIN0) :
                  w_key[1] ? (CREDIT_W+1)'(COIN1) :
                  w_key[2] ? (CREDIT_W+1)'(COIN2) :
                  w_key[3] ? (CREDIT_W+1)'(COIN3) : '0;
  assign w_sum        = {1'b0, r_credit} + w_coin;
  assign w_credit_sat = w_sum[CREDIT_W] ? '1 : w_sum[CREDIT_W-1:0];

`ifdef TICKET_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic        w_active;

  assign w_active = (r_state == S_SESSION) || (r_state == S_SEATS) || (r_state == S_PAY);

  // Inactivity counter, restarted by any key event or cancel and parked outside the active states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= 32'd0;
    end else if (!w_active || (w_fall != 4'd0) || cancel) begin
      r_to_cnt <= 32'd0;
    end else begin
      r_to_cnt <= r_to_cnt + 32'd1;
    end
  end

  assign w_timeout = w_active && (r_to_cnt == 32'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = (TIMEOUT_CYC < 0);
`endif

  assign w_abort = cancel || w_timeout;

  // Next-state and next-value logic; cancel/timeout outrank key events.
  always_comb begin
    w_state_nx   = r_state;
    w_movie_nx   = r_movie;
    w_session_nx = r_session;
    w_due_nx     = r_due;
    w_credit_nx  = r_credit;
    w_change_nx  = r_change;
    w_req_nx     = r_req;
    w_cv_nx      = 1'b0;
    w_err_nx     = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      S_MOVIE: begin
        if (w_key[0]) begin
          w_movie_nx = w_movie_inc;
        end else if (w_key[1]) begin
          w_session_nx = '0;
          w_state_nx   = S_SESSION;
        end else begin
          w_state_nx = S_MOVIE;
        end
      end
      S_SESSION: begin
        if (w_abort) begin
          w_err_nx   = w_timeout;
          w_state_nx = S_MOVIE;
        end else if (w_key[0]) begin
          w_session_nx = w_session_inc;
        end else if (w_key[1]) begin
          if (&w_occ_cur) begin
            w_err_nx = 1'b1;
          end else begin
            w_state_nx = S_SEATS;
          end
        end else if (w_key[2]) begin
          w_state_nx = S_MOVIE;
        end else begin
          w_state_nx = S_SESSION;
        end
      end
      S_SEATS: begin
        if (w_abort) begin
          w_err_nx   = w_timeout;
          w_state_nx = S_MOVIE;
        end else if (w_key[1]) begin
          if ((sw == '0) || ((sw & w_occ_cur) != '0)) begin
            w_err_nx = 1'b1;
          end else begin
            w_req_nx   = sw;
            w_due_nx   = seat_price(sw);
            w_state_nx = S_PAY;
          end
        end else if (w_key[2]) begin
          w_state_nx = S_SESSION;
        end else begin
          w_state_nx = S_SEATS;
        end
      end
      S_PAY: begin
        if (w_abort) begin
          w_err_nx    = w_timeout;
          w_change_nx = r_credit;
          w_cv_nx     = 1'b1;
          w_credit_nx = '0;
          w_due_nx    = '0;
          w_state_nx  = S_MOVIE;
        end else if (r_credit >= r_due) begin
          w_commit    = 1'b1;
          w_change_nx = r_credit - r_due;
          w_cv_nx     = 1'b1;
          w_state_nx  = S_DONE;
        end else if (w_key != 4'd0) begin
          w_credit_nx = w_credit_sat;
        end else begin
          w_state_nx = S_PAY;
        end
      end
      S_DONE: begin
        w_credit_nx = '0;
        w_due_nx    = '0;
        w_state_nx  = S_MOVIE;
      end
      default: begin
        w_state_nx = S_MOVIE;
      end
    endcase
  end

  // Controller registers: state, indices, money and one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_MOVIE;
      r_movie   <= '0;
      r_session <= '0;
      r_due     <= '0;
      r_credit  <= '0;
      r_change  <= '0;
      r_req     <= '0;
      r_cv      <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_movie   <= w_movie_nx;
      r_session <= w_session_nx;
      r_due     <= w_due_nx;
      r_credit  <= w_credit_nx;
      r_change  <= w_change_nx;
      r_req     <= w_req_nx;
      r_cv      <= w_cv_nx;
      r_err     <= w_err_nx;
    end
  end

  // Occupancy map: bits are only ever set by a completed payment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENT; i++) r_occ[i] <= '0;
    end else if (w_commit) begin
      r_occ[w_sel] <= w_occ_cur | r_req;
    end
  end

  assign state        = r_state;
  assign movie_idx    = r_movie;
  assign session_idx  = r_session;
  assign seat_free    = ~w_occ_cur;
  assign due          = r_due;
  assign credit       = r_credit;
  assign change       = r_change;
  assign change_valid = r_cv;
  assign err          = r_err;

endmodule

// File: tb/tb_ticket_booth_ctrl.sv
// Directed self-checking bench for ticket_booth_ctrl (default parameters, TIMEOUT_CYC=100).
module tb_ticket_booth_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key_n = 4'hF;
  logic [17:0] sw = 18'd0;
  logic        cancel = 1'b0;
  logic [2:0]  state;
  logic [0:0]  movie_idx;
  logic [0:0]  session_idx;
  logic [17:0] seat_free;
  logic [9:0]  due, credit, change;
  logic        change_valid, err;

  int n_vec = 0;
  int n_bad = 0;
  int cv_cnt = 0;
  int err_cnt = 0;
  int cv0, e0;
  logic [9:0] last_change = 10'd0;

  ticket_booth_ctrl #(.TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .sw(sw), .cancel(cancel),
    .state(state), .movie_idx(movie_idx), .session_idx(session_idx),
    .seat_free(seat_free), .due(due), .credit(credit), .change(change),
    .change_valid(change_valid), .err(err)
  );

  always #5 clk = ~clk;

  // Pulse monitor on the falling edge: counts high cycles of change_valid and err.
  always @(negedge clk) begin
    if (rst_n) begin
      if (change_valid) begin
        cv_cnt = cv_cnt + 1;
        last_change = change;
      end
      if (err) err_cnt = err_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int k, input int hold);
    key_n[k] = 1'b0;
    tick(hold);
    key_n[k] = 1'b1;
    tick(4);
  endtask

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_movie", 32'(movie_idx), 32'd0);
    chk("rst_session", 32'(session_idx), 32'd0);
    chk("rst_free", 32'(seat_free), 32'h3FFFF);
    chk("rst_due", 32'(due), 32'd0);
    chk("rst_credit", 32'(credit), 32'd0);
    chk("rst_change", 32'(change), 32'd0);
    chk("rst_cv", 32'(change_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // key0 x3 wraps 0->1->0->1; long key1 hold must enter S_SESSION only once
    for (int i = 0; i < 3; i++) press(0, 3);
    chk("movie_wrap", 32'(movie_idx), 32'd1);
    e0 = err_cnt;
    press(1, 1000);
    chk("hold_key1_state", 32'(state), 32'd1);
    chk("hold_key1_noerr", 32'(err_cnt - e0), 32'd0);
    chk("sess_free", 32'(seat_free), 32'h3FFFF);
    press(0, 1000);
    chk("hold_key0_once", 32'(session_idx), 32'd1);
    press(2, 3);
    chk("key2_back", 32'(state), 32'd0);

    // simultaneous key0+key1 in S_MOVIE: key0 wins
    key_n = 4'b1100;
    tick(3);
    key_n = 4'hF;
    tick(4);
    chk("lowest_wins_movie", 32'(movie_idx), 32'd0);
    chk("lowest_wins_state", 32'(state), 32'd0);

    // movie 0 / session 1, two seats, pay 10+20
    press(1, 3);
    press(0, 3);
    press(1, 3);
    chk("seats_state", 32'(state), 32'd2);
    sw = 18'h00005;
    press(1, 3);
    chk("pay_state", 32'(state), 32'd3);
    chk("due_two", 32'(due), 32'd30);
    sw = 18'h3FFFF;
    press(1, 3);
    chk("credit_10", 32'(credit), 32'd10);
    cv0 = cv_cnt;
    press(2, 3);
    chk("exact_cv", 32'(cv_cnt - cv0), 32'd1);
    chk("exact_change", 32'(last_change), 32'd0);
    chk("exact_state", 32'(state), 32'd0);
    chk("exact_credit", 32'(credit), 32'd0);
    chk("exact_free", 32'(seat_free), 32'h3FFFA);
    press(0, 3);
    chk("m1s1_free", 32'(seat_free), 32'h3FFFF);
    press(0, 3);
    chk("m0s1_free", 32'(seat_free), 32'h3FFFA);
    press(1, 3);
    chk("m0s0_free", 32'(seat_free), 32'h3FFFF);

    // rejected seat requests
    press(0, 3);
    press(1, 3);
    e0 = err_cnt;
    sw = 18'h00004;
    press(1, 3);
    chk("sold_err", 32'(err_cnt - e0), 32'd1);
    chk("sold_state", 32'(state), 32'd2);
    sw = 18'h00000;
    press(1, 3);
    chk("empty_err", 32'(err_cnt - e0), 32'd2);
    chk("empty_state", 32'(state), 32'd2);

    // one seat, 50 coin -> change 35
    sw = 18'h00008;
    press(1, 3);
    chk("due_one", 32'(due), 32'd15);
    cv0 = cv_cnt;
    press(3, 3);
    chk("over_cv", 32'(cv_cnt - cv0), 32'd1);
    chk("over_change", 32'(last_change), 32'd35);
    chk("over_state", 32'(state), 32'd0);
    chk("over_free", 32'(seat_free), 32'h3FFF2);

    // three seats (due 45), credit 30, cancel with same-cycle key0 -> refund 30
    press(1, 3);
    press(0, 3);
    press(1, 3);
    sw = 18'h00070;
    press(1, 3);
    chk("due_three", 32'(due), 32'd45);
    press(2, 3);
    press(1, 3);
    chk("credit_30", 32'(credit), 32'd30);
    cv0 = cv_cnt;
    key_n[0] = 1'b0;
    tick(2);
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    key_n[0] = 1'b1;
    tick(4);
    chk("refund_cv", 32'(cv_cnt - cv0), 32'd1);
    chk("refund_change", 32'(last_change), 32'd30);
    chk("refund_credit", 32'(credit), 32'd0);
    chk("refund_due", 32'(due), 32'd0);
    chk("refund_state", 32'(state), 32'd0);
    chk("refund_free", 32'(seat_free), 32'h3FFF2);

    // cancel ignored in S_MOVIE, honoured in S_SESSION
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    tick(1);
    chk("cancel_movie", 32'(state), 32'd0);
    press(1, 3);
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    tick(1);
    chk("cancel_session", 32'(state), 32'd0);

`ifdef TICKET_TIMEOUT_EN
    press(1, 3);
    press(0, 3);
    press(1, 3);
    sw = 18'h00300;
    press(1, 3);
    press(2, 3);
    chk("to_credit", 32'(credit), 32'd20);
    cv0 = cv_cnt;
    e0 = err_cnt;
    tick(110);
    chk("to_err", 32'(err_cnt - e0), 32'd1);
    chk("to_cv", 32'(cv_cnt - cv0), 32'd1);
    chk("to_change", 32'(last_change), 32'd20);
    chk("to_state", 32'(state), 32'd0);
    chk("to_credit0", 32'(credit), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
